// File: rtl/fetch_pkg.sv
// Shared types and constants for the buffered instruction fetch unit.
// Holds the FIFO entry layout, the fetch state encoding and the default boot address.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: power-of-two circular FIFO with synchronous flush and occupancy count.
// Simultaneous push and pop are accepted even when full.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  entry_t                       i_wdata,
  input  logic                         i_pop,
  output entry_t                       o_rdata,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic            w_full;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; the count alone decides validity,
  // so the array maps onto plain RAM without a reset network.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/buffered_fetch.sv
// Prefetching instruction fetch unit with credit-based issue, in-order responses and redirect flush.
// Define FETCH_MISALIGN_CHECK_EN to turn misaligned redirects into a fault entry followed by HALT.
module buffered_fetch
  import fetch_pkg::*;
#(
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        fault_o,
  input  logic        stall_i,
  input  logic [31:0] pc_i,
  input  logic        new_pc_i,
  output logic        req_o,
  output logic [31:0] addr_o,
  input  logic        gnt_i,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic MISALIGN_EN = 1'b1;
`else
  localparam logic MISALIGN_EN = 1'b0;
`endif

  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_resp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;

  logic [CW-1:0] w_count;
  logic          w_empty;
  fetch_entry_t  w_head;
  fetch_entry_t  w_wdata;
  logic [CW:0]   w_inflight;
  logic          w_credit;
  logic          w_blocked;
  logic          w_req;
  logic          w_gnt;
  logic          w_rsp;
  logic [CW-1:0] w_out_after_rsp;
  logic          w_keep;
  logic          w_fault_wr;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_redirect_pc;

  // Issue only while every granted request is guaranteed a FIFO slot on return.
  assign w_inflight = {1'b0, w_count} + {1'b0, r_outstanding};
  assign w_credit   = (w_inflight < (CW+1)'(FIFO_DEPTH))
                   && (r_outstanding < CW'(MAX_OUTSTANDING));
  assign w_req      = rstn_i && w_credit && !new_pc_i && !w_blocked;
  assign w_gnt      = w_req && gnt_i;

  // Responses with nothing outstanding (e.g. stale ones after a reset) are ignored.
  assign w_rsp           = rvalid_i && (r_outstanding != '0);
  assign w_out_after_rsp = r_outstanding - CW'(w_rsp);
  assign w_keep          = w_rsp && !new_pc_i && (r_discard == '0);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic         r_fault_pend;
  fetch_state_t r_state;

  assign w_blocked     = r_fault_pend || (r_state == HALT);
  assign w_fault_wr    = r_fault_pend && (r_discard == '0) && !new_pc_i;
  assign w_redirect_pc = pc_i;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_fault_pend <= 1'b0;
      r_state      <= RUN;
    end else if (new_pc_i) begin
      r_fault_pend <= (pc_i[1:0] != 2'b00);
      r_state      <= RUN;
    end else if (w_fault_wr) begin
      r_fault_pend <= 1'b0;
      r_state      <= HALT;
    end
  end
`else
  assign w_blocked     = 1'b0;
  assign w_fault_wr    = 1'b0;
  assign w_redirect_pc = pc_i & ~32'h3;
`endif

  assign w_push = w_keep || w_fault_wr;
  assign w_pop  = !w_empty && !stall_i && !new_pc_i;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_wdata       = '0;
    w_wdata.instr = rdata_i;
    w_wdata.pc    = r_resp_pc;
    if (w_fault_wr) begin
      w_wdata.instr = 32'h0;
      w_wdata.fault = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (new_pc_i) begin
      r_fetch_pc    <= w_redirect_pc;
      r_resp_pc     <= w_redirect_pc;
      r_outstanding <= w_out_after_rsp;
      r_discard     <= w_out_after_rsp;
    end else begin
      if (w_gnt)  r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_keep) r_resp_pc  <= r_resp_pc + 32'd4;
      r_outstanding <= w_out_after_rsp + CW'(w_gnt);
      if (w_rsp && (r_discard != '0)) r_discard <= r_discard - CW'(1);
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rstn_i),
    .i_flush (new_pc_i),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign valid_o = !w_empty;
  assign instr_o = valid_o ? w_head.instr : 32'h0;
  assign pc_o    = valid_o ? w_head.pc    : 32'h0;
  assign fault_o = valid_o && w_head.fault && MISALIGN_EN;
  assign req_o   = w_req;
  assign addr_o  = r_fetch_pc;

endmodule

// File: doc/buffered_fetch.md
BUFFERED_FETCH -- requirements
Module: buffered_fetch

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set instruction buffer entries; power of two, at least 2.
REQ-002 Parameter MAX_OUTSTANDING, default 2, SHALL set the maximum granted but unanswered memory requests; range 1..FIFO_DEPTH.
REQ-003 Parameter RESET_PC, default 32'h8000_0000, SHALL set the first fetch address.
REQ-004 Ports SHALL be, in order:
- clk_i, input, 1: the single clock; reset is synchronous and active-low.
- rstn_i, input, 1: synchronous, active-low reset.
- valid_o, output, 1: buffer head holds an instruction.
- instr_o, output, 32: instruction at head.
- pc_o, output, 32: address of head instruction.
- fault_o, output, 1: head entry is a misaligned-fetch fault.
- stall_i, input, 1: CPU cannot accept; head consumed when valid_o=1 and stall_i=0.
- pc_i, input, 32: redirect target.
- new_pc_i, input, 1: redirect strobe.
- req_o, output, 1: memory read request.
- addr_o, output, 32: request address.
- gnt_i, input, 1: request accepted this cycle.
- rvalid_i, input, 1: response data valid.
- rdata_i, input, 32: response data; responses return in request order.

Function
REQ-005 Issue: req_o SHALL be 1 when (fifo_count + outstanding) < FIFO_DEPTH, outstanding < MAX_OUTSTANDING, new_pc_i=0 and the block is not halted on a fault.
REQ-006 A granted request is req_o and gnt_i both 1; it SHALL advance fetch_pc by 4 (mod 2^32) and increment outstanding.
REQ-007 While req_o=1 and gnt_i=0, addr_o SHALL hold stable.
REQ-008 addr_o SHALL equal fetch_pc at all times.
REQ-009 rvalid_i SHALL decrement outstanding.
REQ-010 When not discarding, rvalid_i SHALL write {rdata_i, pc} into the FIFO tail; pc comes from a response-pc counter that advances by 4 per accepted response.
REQ-011 The credit rule in REQ-005 SHALL guarantee FIFO space for every response; no backpressure to memory.
REQ-012 Latency: an entry written on edge N SHALL drive valid_o in cycle N+1. There is no bypass. Minimum latency is 2 cycles from request to valid_o, given gnt_i in the request cycle and rvalid_i in the next cycle.
REQ-013 Simultaneous FIFO write and consume SHALL keep the count unchanged, including when the FIFO is full.
REQ-014 When the FIFO is empty, valid_o=0; instr_o, pc_o and fault_o are don't-care.
REQ-015 Redirect: on new_pc_i=1 in cycle N:
- The FIFO SHALL be flushed at edge N.
- Any consumption in cycle N SHALL be ignored.
- req_o SHALL be 0 in cycle N.
- fetch_pc and the response-pc counter SHALL load pc_i.
- discard_count SHALL load the outstanding count after any rvalid_i in cycle N. That cycle-N response is itself dropped.
REQ-016 While discard_count>0, each rvalid_i SHALL decrement it and its data SHALL be dropped. Issue SHALL still proceed under REQ-005.
REQ-017 Back-to-back new_pc_i SHALL behave as repeated redirects; the last one wins.
REQ-018 State machine:
- RUN SHALL be the normal fetch state.
- HALT (only with REQ-023) SHALL be entered after a fault entry is written; no requests are issued in HALT.
- new_pc_i SHALL return HALT to RUN.

Reset
REQ-019 While rstn_i=0 at a clock edge, the block SHALL reset synchronously:
- FIFO empty, outstanding=0, discard_count=0.
- fetch_pc and the response-pc counter = RESET_PC.
- State = RUN.
REQ-020 Output values with reset applied: valid_o=0, fault_o=0, req_o=0, addr_o=RESET_PC, instr_o=0, pc_o=0.
REQ-021 In the first cycle after reset release, req_o SHALL be 1 with addr_o=RESET_PC.
REQ-022 Responses arriving after a mid-operation reset SHALL be ignored until the first post-reset request is granted. The memory model is reset together with the block.

Configuration
REQ-023 With FETCH_MISALIGN_CHECK_EN defined, a redirect with pc_i[1:0] != 0 SHALL NOT issue requests. Instead, after the discards complete, one FIFO entry SHALL be written with fault_o=1, pc_o=pc_i and instr_o=0, and the block enters HALT.
REQ-024 Without FETCH_MISALIGN_CHECK_EN, pc_i[1:0] SHALL be forced to 0, fault_o SHALL be tied 0, and HALT SHALL not exist.

Structure
REQ-025 A shared package fetch_pkg SHALL hold:
- the FIFO entry typedef {instr, pc, fault};
- the state enum {RUN, HALT};
- the RESET_PC default constant.
REQ-026 The FIFO SHALL be a separate sub-module, fetch_fifo, parametrised by depth and entry type, with a flush input and count output.

Verification
REQ-027 Reset release with a zero-wait memory (gnt_i=1, rvalid_i one cycle later) and stall_i=0 -> addresses 8000_0000, 8000_0004, ... are issued every cycle; valid_o first rises 2 cycles after reset release with pc_o=8000_0000.
REQ-028 stall_i=1 held for 10 cycles -> the FIFO fills to 4 and req_o drops; releasing stall_i gives 4 consecutive valid entries with pc_o values in order and no gaps or duplicates.
REQ-029 new_pc_i with pc_i=8000_0100 while 2 requests are outstanding -> both responses are dropped; the next valid_o shows pc_o=8000_0100 with the instruction from that address.
REQ-030 gnt_i held 0 for 5 cycles -> addr_o stays constant; after gnt_i, no request is lost or duplicated.
REQ-031 With FETCH_MISALIGN_CHECK_EN defined, new_pc_i with pc_i=8000_0102 -> exactly one entry with fault_o=1 and pc_o=8000_0102, no further requests, and recovery on the next aligned new_pc_i.
REQ-032 Fetch at fetch_pc=FFFF_FFFC -> the next address is 0000_0000.
